// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - LCD op/state encodings and default bus timing shared by reader and writer
package lcd_pkg;

    typedef enum logic [1:0] {
        OP_RD_BF   = 2'b00,
        OP_RD_DATA = 2'b01,
        OP_WAIT    = 2'b10,
        OP_ILLEGAL = 2'b11
    } lcd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_E_HIGH = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5
    } lcd_state_t;

    localparam int T_AS_DEF     = 3;
    localparam int T_EH_DEF     = 12;
    localparam int T_AH_DEF     = 2;
    localparam int T_GAP_DEF    = 50;
    localparam int POLL_MAX_DEF = 4096;

    // One shared width for every phase timer, sized so the longest phase never wraps.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// rtl/lcd_reader_if.sv - request/response and LCD pin bundle of the LCD reader
interface lcd_reader_if;
    logic       req;
    logic [1:0] op;
    logic       ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_busy;
    logic [6:0] rsp_addr;
    logic       rsp_err;
    logic       rs;
    logic       rw;
    logic       ena;
    logic [7:0] dat_in;

    modport slave (
        input  req, op, dat_in,
        output ready, rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_err, rs, rw, ena
    );

    modport master (
        output req, op, dat_in,
        input  ready, rsp_valid, rsp_data, rsp_busy, rsp_addr, rsp_err, rs, rw, ena
    );
endinterface

// File: rtl/lcd_rd_cycle.sv
// rtl/lcd_rd_cycle.sv - one timed LCD read strobe (SETUP, E_HIGH, HOLD) with start/done
module lcd_rd_cycle
    import lcd_pkg::*;
#(
    parameter int T_AS = T_AS_DEF,
    parameter int T_EH = T_EH_DEF,
    parameter int T_AH = T_AH_DEF,
    parameter int CW   = timer_width(T_AS_DEF, T_EH_DEF, T_AH_DEF, T_GAP_DEF)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] dat_i,
    output logic       rs_o,
    output logic       rw_o,
    output logic       ena_o,
    output logic       done_o,
    output logic [7:0] data_o
);

    localparam logic [CW-1:0] AS_LAST = CW'(T_AS - 1);
    localparam logic [CW-1:0] EH_LAST = CW'(T_EH - 1);
    localparam logic [CW-1:0] AH_LAST = CW'(T_AH - 1);

    lcd_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        rs_d    = rs_q;
        data_d  = data_q;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = ST_SETUP;
                    rs_d    = rs_i;
                end
            end
            ST_SETUP: begin
                if (cnt_q == AS_LAST) begin
                    state_d = ST_E_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_E_HIGH: begin
                // The panel's data is only trusted on the last cycle of the strobe.
                if (cnt_q == EH_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    data_d  = dat_i;
                end
            end
            ST_HOLD: begin
                if (cnt_q == AH_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_o  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rw_o   = (state_q != ST_IDLE);
    assign rs_o   = rw_o & rs_q;
    assign ena_o  = (state_q == ST_E_HIGH);
    assign data_o = data_q;

endmodule

// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - LCD read sequencer: status/data reads, busy-flag polling, inter-cycle gap
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_AS     = T_AS_DEF,
    parameter int T_EH     = T_EH_DEF,
    parameter int T_AH     = T_AH_DEF,
    parameter int T_GAP    = T_GAP_DEF,
    parameter int POLL_MAX = POLL_MAX_DEF
) (
    input logic         clk,
    input logic         rst_n,
    lcd_reader_if.slave bus
);

    localparam int CW = timer_width(T_AS, T_EH, T_AH, T_GAP);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(T_GAP - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

    logic [1:0]    rst_sync_q;
    logic          arst_n;

    lcd_state_t    state_q, state_d;
    lcd_op_t       op_q, op_d;
    lcd_op_t       req_op;
    logic [PW-1:0] poll_q, poll_d;
    logic [CW-1:0] gap_q, gap_d;
    logic          fin_q, fin_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_busy_q, rsp_busy_d;
    logic [6:0]    rsp_addr_q, rsp_addr_d;
    logic          rsp_err_q, rsp_err_d;

    logic          cyc_start;
    logic          cyc_rs;
    logic          cyc_done;
    logic [7:0]    cyc_data;

    // Assertion is immediate; release reaches the logic only after two clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign arst_n = rst_sync_q[1];

    assign req_op = lcd_op_t'(bus.op);

    lcd_rd_cycle #(
        .T_AS (T_AS),
        .T_EH (T_EH),
        .T_AH (T_AH),
        .CW   (CW)
    ) u_cycle (
        .clk     (clk),
        .rst_n   (arst_n),
        .start_i (cyc_start),
        .rs_i    (cyc_rs),
        .dat_i   (bus.dat_in),
        .rs_o    (bus.rs),
        .rw_o    (bus.rw),
        .ena_o   (bus.ena),
        .done_o  (cyc_done),
        .data_o  (cyc_data)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_RD_BF;
            poll_q      <= '0;
            gap_q       <= '0;
            fin_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_busy_q  <= 1'b0;
            rsp_addr_q  <= 7'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            poll_q      <= poll_d;
            gap_q       <= gap_d;
            fin_q       <= fin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_busy_q  <= rsp_busy_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // ST_SETUP here spans the whole read strobe; lcd_rd_cycle walks SETUP/E_HIGH/HOLD.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        poll_d      = poll_q;
        gap_d       = gap_q;
        fin_d       = fin_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_busy_d  = rsp_busy_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_err_d   = rsp_err_q;
        cyc_start   = 1'b0;
        cyc_rs      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    op_d   = req_op;
                    poll_d = '0;
                    gap_d  = '0;
                    fin_d  = 1'b0;
                    if (req_op == OP_ILLEGAL) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_SETUP;
                        cyc_start = 1'b1;
                        cyc_rs    = (req_op == OP_RD_DATA);
                    end
                end
            end
            ST_SETUP: begin
                if (cyc_done) begin
                    poll_d = poll_q + 1'b1;
                    if (op_q == OP_WAIT && cyc_data[7] && poll_q != POLL_LAST) state_d = ST_GAP;
                    else                                                       state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid_d = 1'b1;
                fin_d       = 1'b1;
                if (op_q == OP_ILLEGAL) begin
                    rsp_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    // A wait op that ends with the busy flag still set has run out of polls.
                    rsp_data_d = cyc_data;
                    rsp_busy_d = (op_q != OP_RD_DATA) && cyc_data[7];
                    rsp_addr_d = (op_q != OP_RD_DATA) ? cyc_data[6:0] : 7'h00;
                    rsp_err_d  = (op_q == OP_WAIT) && cyc_data[7];
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (fin_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_SETUP;
                        cyc_start = 1'b1;
                        cyc_rs    = (op_q == OP_RD_DATA);
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_busy  = rsp_busy_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lcd_reader.sv
// tb/tb_lcd_reader.sv - directed self-checking bench for lcd_reader
module tb_lcd_reader;

    localparam int POLL_MAX = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_reader_if bif();

    lcd_reader #(
        .T_AS     (3),
        .T_EH     (12),
        .T_AH     (2),
        .T_GAP    (50),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int nvec = 0;
    int nerr = 0;

    // Panel model: returns the next scripted byte while ena is high, junk otherwise.
    logic [7:0] panel_seq [0:15];
    logic [3:0] rd_idx = 4'd0;
    assign bif.dat_in = bif.ena ? panel_seq[rd_idx] : 8'h3C;

    int   cyc = 0;
    int   acc_cyc = 0;
    int   ena_rises, ena_hi, rw_hi, rs_hi, rs_bad, vld_cnt, first_rise, last_fall, min_gap;
    logic ena_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bif.ena && !ena_prev) begin
            if (ena_rises == 0) first_rise = cyc;
            else if (cyc - last_fall < min_gap) min_gap = cyc - last_fall;
            ena_rises++;
        end
        if (!bif.ena && ena_prev) begin
            last_fall = cyc;
            if (rd_idx != 4'd15) rd_idx = rd_idx + 4'd1;
        end
        if (bif.ena) ena_hi++;
        if (bif.rw) rw_hi++;
        if (bif.rs) rs_hi++;
        if (bif.rw && !bif.rs) rs_bad++;
        if (bif.rsp_valid) vld_cnt++;
        ena_prev = bif.ena;
    end

    task automatic clear_mon();
        ena_rises = 0; ena_hi = 0; rw_hi = 0; rs_hi = 0; rs_bad = 0; vld_cnt = 0;
        first_rise = -1; last_fall = 0; min_gap = 1000000; rd_idx = 4'd0;
    endtask

    task automatic start_op(input logic [1:0] op);
        @(negedge clk);
        nvec++;
        if (bif.ready !== 1'b1) begin nerr++; $display("FAIL ready_before_req: got %b want 1", bif.ready); end
        #1;
        clear_mon();
        bif.req = 1'b1;
        bif.op  = op;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        bif.req = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int lat);
        lat = 0;
        while (bif.rsp_valid !== 1'b1 && lat < budget) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (bif.ready !== 1'b1 && n < budget) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        nvec++; if (bif.ready !== 1'b1)     begin nerr++; $display("FAIL rst_ready: got %b want 1", bif.ready); end
        nvec++; if (bif.rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", bif.rsp_valid); end
        nvec++; if (bif.rsp_data !== 8'h00) begin nerr++; $display("FAIL rst_data: got %h want 00", bif.rsp_data); end
        nvec++; if (bif.rsp_busy !== 1'b0)  begin nerr++; $display("FAIL rst_busy: got %b want 0", bif.rsp_busy); end
        nvec++; if (bif.rsp_addr !== 7'h00) begin nerr++; $display("FAIL rst_addr: got %h want 00", bif.rsp_addr); end
        nvec++; if (bif.rsp_err !== 1'b0)   begin nerr++; $display("FAIL rst_err: got %b want 0", bif.rsp_err); end
        nvec++; if ({bif.rs, bif.rw, bif.ena} !== 3'b000) begin nerr++; $display("FAIL rst_pins: got rs/rw/ena=%b want 000", {bif.rs, bif.rw, bif.ena}); end
    endtask

    task automatic test_read_bf();
        int lat, n;
        panel_seq[0] = 8'h85;
        start_op(2'b00);
        wait_rsp(100, lat);
        nvec++; if (lat != 18) begin nerr++; $display("FAIL bf_latency: got %0d want 18", lat); end
        nvec++; if (bif.rsp_data !== 8'h85) begin nerr++; $display("FAIL bf_data: got %h want 85", bif.rsp_data); end
        nvec++; if (bif.rsp_busy !== 1'b1)  begin nerr++; $display("FAIL bf_busy: got %b want 1", bif.rsp_busy); end
        nvec++; if (bif.rsp_addr !== 7'h05) begin nerr++; $display("FAIL bf_addr: got %h want 05", bif.rsp_addr); end
        nvec++; if (bif.rsp_err !== 1'b0)   begin nerr++; $display("FAIL bf_err: got %b want 0", bif.rsp_err); end
        wait_ready(200, n);
        nvec++; if (n != 50) begin nerr++; $display("FAIL bf_gap_to_ready: got %0d want 50", n); end
        nvec++; if (first_rise - acc_cyc != 3) begin nerr++; $display("FAIL bf_ena_setup: got %0d want 3", first_rise - acc_cyc); end
        nvec++; if (ena_hi != 12)   begin nerr++; $display("FAIL bf_ena_width: got %0d want 12", ena_hi); end
        nvec++; if (ena_rises != 1) begin nerr++; $display("FAIL bf_ena_pulses: got %0d want 1", ena_rises); end
        nvec++; if (rw_hi != 17)    begin nerr++; $display("FAIL bf_rw_width: got %0d want 17", rw_hi); end
        nvec++; if (rs_hi != 0)     begin nerr++; $display("FAIL bf_rs_low: got %0d want 0", rs_hi); end
        nvec++; if (vld_cnt != 1)   begin nerr++; $display("FAIL bf_valid_pulse: got %0d want 1", vld_cnt); end
    endtask

    task automatic test_read_data();
        int lat, n;
        panel_seq[0] = 8'h48;
        start_op(2'b01);
        wait_rsp(100, lat);
        nvec++; if (lat != 18) begin nerr++; $display("FAIL dat_latency: got %0d want 18", lat); end
        nvec++; if (bif.rsp_data !== 8'h48) begin nerr++; $display("FAIL dat_data: got %h want 48", bif.rsp_data); end
        nvec++; if (bif.rsp_busy !== 1'b0)  begin nerr++; $display("FAIL dat_busy: got %b want 0", bif.rsp_busy); end
        nvec++; if (bif.rsp_addr !== 7'h00) begin nerr++; $display("FAIL dat_addr: got %h want 00", bif.rsp_addr); end
        wait_ready(200, n);
        nvec++; if (rs_hi != 17) begin nerr++; $display("FAIL dat_rs_width: got %0d want 17", rs_hi); end
        nvec++; if (rs_bad != 0) begin nerr++; $display("FAIL dat_rs_drop: got %0d want 0", rs_bad); end
    endtask

    task automatic test_wait_poll();
        int lat, n;
        panel_seq[0] = 8'h80; panel_seq[1] = 8'h80; panel_seq[2] = 8'h80; panel_seq[3] = 8'h12;
        start_op(2'b10);
        wait_rsp(400, lat);
        nvec++; if (lat != 219) begin nerr++; $display("FAIL poll_latency: got %0d want 219", lat); end
        nvec++; if (bif.rsp_addr !== 7'h12) begin nerr++; $display("FAIL poll_addr: got %h want 12", bif.rsp_addr); end
        nvec++; if (bif.rsp_busy !== 1'b0)  begin nerr++; $display("FAIL poll_busy: got %b want 0", bif.rsp_busy); end
        nvec++; if (bif.rsp_err !== 1'b0)   begin nerr++; $display("FAIL poll_err: got %b want 0", bif.rsp_err); end
        wait_ready(200, n);
        nvec++; if (ena_rises != 4) begin nerr++; $display("FAIL poll_pulses: got %0d want 4", ena_rises); end
        nvec++; if (min_gap < 50)   begin nerr++; $display("FAIL poll_spacing: got %0d want >=50", min_gap); end
        nvec++; if (vld_cnt != 1)   begin nerr++; $display("FAIL poll_valid_pulse: got %0d want 1", vld_cnt); end
    endtask

    task automatic test_wait_timeout();
        int lat, n;
        for (int i = 0; i < 16; i++) panel_seq[i] = 8'hFF;
        start_op(2'b10);
        wait_rsp(700, lat);
        nvec++; if (lat != 487) begin nerr++; $display("FAIL tmo_latency: got %0d want 487", lat); end
        nvec++; if (bif.rsp_err !== 1'b1)   begin nerr++; $display("FAIL tmo_err: got %b want 1", bif.rsp_err); end
        nvec++; if (bif.rsp_data !== 8'hFF) begin nerr++; $display("FAIL tmo_data: got %h want FF", bif.rsp_data); end
        nvec++; if (bif.rsp_addr !== 7'h7F) begin nerr++; $display("FAIL tmo_addr: got %h want 7F", bif.rsp_addr); end
        wait_ready(200, n);
        repeat (20) @(negedge clk);
        #1;
        nvec++; if (ena_rises != POLL_MAX) begin nerr++; $display("FAIL tmo_pulses: got %0d want %0d", ena_rises, POLL_MAX); end
    endtask

    task automatic test_illegal();
        int lat, n;
        start_op(2'b11);
        wait_rsp(20, lat);
        nvec++; if (lat != 1) begin nerr++; $display("FAIL ill_latency: got %0d want 1", lat); end
        nvec++; if (bif.rsp_err !== 1'b1) begin nerr++; $display("FAIL ill_err: got %b want 1", bif.rsp_err); end
        wait_ready(20, n);
        repeat (10) @(negedge clk);
        #1;
        nvec++; if (rw_hi != 0)   begin nerr++; $display("FAIL ill_rw: got %0d want 0", rw_hi); end
        nvec++; if (vld_cnt != 1) begin nerr++; $display("FAIL ill_valid_pulse: got %0d want 1", vld_cnt); end
    endtask

    task automatic test_back_to_back();
        int n;
        panel_seq[0] = 8'h5A;
        start_op(2'b00);
        n = 0;
        while (bif.ready !== 1'b1 && n < 200) begin
            bif.req = ((n % 3) == 1);
            bif.op  = 2'b01;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        bif.req = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        nvec++; if (vld_cnt != 1)   begin nerr++; $display("FAIL b2b_valid_count: got %0d want 1", vld_cnt); end
        nvec++; if (ena_rises != 1) begin nerr++; $display("FAIL b2b_pulses: got %0d want 1", ena_rises); end
        nvec++; if (bif.rsp_addr !== 7'h5A) begin nerr++; $display("FAIL b2b_addr: got %h want 5A", bif.rsp_addr); end
        nvec++; if (bif.ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready: got %b want 1", bif.ready); end
    endtask

    task automatic test_reset_mid();
        int n, lat;
        panel_seq[0] = 8'h85;
        start_op(2'b00);
        repeat (4) @(negedge clk);
        nvec++; if (bif.ena !== 1'b1) begin nerr++; $display("FAIL mid_in_ehigh: got %b want 1", bif.ena); end
        #1 rst_n = 1'b0;
        #1;
        nvec++; if ({bif.ena, bif.rw} !== 2'b00) begin nerr++; $display("FAIL mid_pins: got ena/rw=%b want 00", {bif.ena, bif.rw}); end
        nvec++; if (bif.ready !== 1'b1)    begin nerr++; $display("FAIL mid_ready: got %b want 1", bif.ready); end
        nvec++; if (bif.rsp_data !== 8'h00) begin nerr++; $display("FAIL mid_data: got %h want 00", bif.rsp_data); end
        repeat (3) @(negedge clk);
        #1;
        nvec++; if (vld_cnt != 0) begin nerr++; $display("FAIL mid_no_valid: got %0d want 0", vld_cnt); end
        clear_mon();
        panel_seq[0] = 8'h2A;
        rst_n   = 1'b1;
        bif.req = 1'b1;
        bif.op  = 2'b00;
        n = 0;
        while (bif.ready === 1'b1 && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        bif.req = 1'b0;
        nvec++; if (n < 2 || n > 4) begin nerr++; $display("FAIL mid_release_accept: got %0d want 2..4", n); end
        wait_rsp(100, lat);
        nvec++; if (lat != 18) begin nerr++; $display("FAIL mid_latency: got %0d want 18", lat); end
        nvec++; if (bif.rsp_addr !== 7'h2A) begin nerr++; $display("FAIL mid_addr: got %h want 2A", bif.rsp_addr); end
        nvec++; if (bif.rsp_busy !== 1'b0)  begin nerr++; $display("FAIL mid_busy: got %b want 0", bif.rsp_busy); end
        wait_ready(200, n);
        nvec++; if (vld_cnt != 1) begin nerr++; $display("FAIL mid_valid_pulse: got %0d want 1", vld_cnt); end
    endtask

    initial begin
        bif.req = 1'b0;
        bif.op  = 2'b00;
        for (int i = 0; i < 16; i++) panel_seq[i] = 8'h00;
        clear_mon();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_read_bf();
        test_read_data();
        test_wait_poll();
        test_wait_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 Parameter T_AS, default 3: clk cycles rs/rw are stable before ena rises.
REQ-002 Parameter T_EH, default 12: clk cycles ena is held high.
REQ-003 Parameter T_AH, default 2: clk cycles rs/rw are held after ena falls.
REQ-004 Parameter T_GAP, default 50: idle clk cycles between bus cycles and before ready returns.
REQ-005 Parameter POLL_MAX, default 4096: maximum busy-flag reads per wait operation.
REQ-006 Port clk, input, 1: single clock; all logic on rising edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port req, input, 1: operation request.
REQ-009 Port op, input, 2: 00 read BF/AC, 01 read DDRAM/CGRAM data, 10 wait-not-busy, 11 illegal.
REQ-010 Port ready, output, 1: block idle and able to accept req.
REQ-011 Port rsp_valid, output, 1: one-cycle completion pulse.
REQ-012 Port rsp_data, output, 8: last byte sampled from the panel.
REQ-013 Port rsp_busy, output, 1: rsp_data[7] for ops 00/10; 0 for op 01.
REQ-014 Port rsp_addr, output, 7: rsp_data[6:0] for ops 00/10; 0 for op 01.
REQ-015 Port rsp_err, output, 1: illegal op or wait timeout; valid with rsp_valid.
REQ-016 Port rs, output, 1: LCD register select.
REQ-017 Port rw, output, 1: LCD read/write; 1 means the panel drives dat_in and the top level tristates its data driver.
REQ-018 Port ena, output, 1: LCD enable strobe.
REQ-019 Port dat_in, input, 8: LCD data bus, input side.

Function
REQ-020 Handshake: accept when req=1 and ready=1 on the same edge; latch op; ready=0 from the next cycle until return to IDLE.
REQ-021 States: IDLE, SETUP, E_HIGH, HOLD, GAP, DONE; ready=1 only in IDLE.
REQ-022 IDLE outputs: rs=0, rw=0, ena=0.
REQ-023 Bus cycle: on entry to SETUP, drive rw=1 and rs=op[0] (rs=0 for op 10).
REQ-024 ena rises T_AS cycles after SETUP entry and stays high exactly T_EH cycles.
REQ-025 dat_in is registered on the final E_HIGH cycle only.
REQ-026 After ena falls, rs/rw are held for T_AH cycles; rw returns to 0 on the following edge.
REQ-027 Ops 00/01: rsp_valid pulses at acceptance edge + T_AS+T_EH+T_AH+1 (18 cycles at defaults), then GAP for T_GAP cycles, then IDLE.
REQ-028 Op 10: repeat BF/AC bus cycles, separated by T_GAP, until sampled bit7=0; then rsp_valid with rsp_err=0 and the last sample.
REQ-029 Op 10 timeout: after POLL_MAX reads all showing bit7=1, rsp_valid with rsp_err=1 and the last sample; no further reads.
REQ-030 Op 11: no bus activity (rw stays 0); rsp_valid with rsp_err=1 one cycle after acceptance; then IDLE.
REQ-031 rsp_valid has no backpressure; rsp_* fields hold until the next rsp_valid.
REQ-032 req while ready=0 is ignored and not queued.
REQ-033 Poll counter width is $clog2(POLL_MAX+1); timing counters are sized from the largest of T_AS/T_EH/T_AH/T_GAP; none wrap.

Reset
REQ-034 rst_n=0 forces IDLE and rs=rw=ena=0 asynchronously, including mid-cycle with ena high.
REQ-035 rst_n=0 forces rsp_valid=0, rsp_data=0, rsp_busy=0, rsp_addr=0, rsp_err=0, poll counter=0, and ready=1.
REQ-036 Deassertion is synchronized to clk; the first req is accepted no earlier than the second edge after deassertion.

Structure
REQ-037 Package lcd_pkg holds op encodings, state encoding, and default timing constants, shared with the LCD writer.
REQ-038 One sub-module, lcd_rd_cycle, executes a single timed read (SETUP/E_HIGH/HOLD) with start/done; lcd_reader sequences ops, polling, and GAP around it.

Verification
REQ-039 op=00, dat_in=8'h85 -> ena high 12 cycles, rsp_valid at +18, rsp_busy=1, rsp_addr=7'h05, rsp_err=0.
REQ-040 op=01, dat_in=8'h48 -> rs=1 throughout the cycle, rsp_data=8'h48, rsp_busy=0, rsp_addr=0.
REQ-041 op=10, dat_in=8'h80 for 3 reads then 8'h12 -> exactly 4 ena pulses 50+ cycles apart, rsp_addr=7'h12, rsp_err=0.
REQ-042 op=10, POLL_MAX=8, dat_in stuck 8'hFF -> 8 ena pulses, then rsp_err=1.
REQ-043 op=11 -> rsp_err=1 one cycle after acceptance, rw never 1; req pulses while busy -> no extra transactions.
REQ-044 rst_n low during E_HIGH -> ena/rw low immediately, no rsp_valid, ready=1; the next op=00 completes normally.
